gemv_stream: RTL

- Next-generation GEMV engine. Computes y = requant(W·x + b) for a runtime-sized matrix, up to MAX_ROWS x MAX_COLS.
- Operands arrive on valid/ready streams, not as full parallel arrays. Results leave one int8 per row on a valid/ready output stream.
- Adds over the previous GEMV: runtime dimensions, optional ReLU, shift-based requantisation with rounding and saturation, and output backpressure.
- Sits between the weight/activation buffers and the next layer's input buffer.

---
 rtl/gemv_stream.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/gemv_stream.sv
// Streaming GEMV engine: y = requant(W*x + b), one int8 result per row.
// x is buffered once per job; each row then streams a bias and T weight
// tiles through TILE_SIZE parallel MAC lanes, followed by a rounding,
// saturating right-shift requantisation and a valid/ready result beat.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; bad cfg pulses err/done here
// LOAD_X   | accepting T x tiles into the x buffer
// BIAS     | accepting this row's bias into the accumulator
// MAC      | accepting T weight tiles, one dot-product tile per beat
// REQUANT  | ReLU, round, shift and saturate into y_data
// OUTPUT   | holding the result until the consumer takes it
// DONE     | one-cycle end-of-job pulse
module gemv_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_ROWS   = 128,
    parameter int MAX_COLS   = 128,
    parameter int TILE_SIZE  = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [$clog2(MAX_ROWS+1)-1:0]   rows_cfg,
    input  logic [$clog2(MAX_COLS+1)-1:0]   cols_cfg,
    input  logic                            relu_en,
    input  logic [4:0]                      shift,
    input  logic                            x_valid,
    output logic                            x_ready,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0] x_data,
    input  logic                            w_valid,
    output logic                            w_ready,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0] w_data,
    input  logic                            b_valid,
    output logic                            b_ready,
    input  logic [DATA_WIDTH-1:0]           b_data,
    output logic                            y_valid,
    input  logic                            y_ready,
    output logic [DATA_WIDTH-1:0]           y_data,
    output logic                            y_last,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam int DW        = DATA_WIDTH;
    localparam int PW        = 2 * DATA_WIDTH;
    localparam int RW        = $clog2(MAX_ROWS + 1);
    localparam int CW        = $clog2(MAX_COLS + 1);
    localparam int MAX_TILES = (MAX_COLS + TILE_SIZE - 1) / TILE_SIZE;
    localparam int TW        = $clog2(MAX_TILES + 1);
    localparam int IW        = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1;
    localparam int LW        = $clog2(TILE_SIZE + 1);
    localparam int TDW       = TILE_SIZE * DATA_WIDTH;

    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'(2**(DATA_WIDTH-1) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH+1)'(-(2**(DATA_WIDTH-1)));

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_X, S_BIAS, S_MAC, S_REQUANT, S_OUTPUT, S_DONE
    } state_t;

    state_t                       state;
    logic [RW-1:0]                rows_left;
    logic [TW-1:0]                tiles_q;
    logic [TW-1:0]                tile_left;
    logic [IW-1:0]                tile_idx;
    logic [LW-1:0]                last_lanes;
    logic                         relu_q;
    logic [4:0]                   shift_q;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic [TDW-1:0]               x_buf [MAX_TILES];

    logic                         cfg_ok;
    logic [CW:0]                  cols_round;
    logic [TW-1:0]                tiles_calc;
    logic [LW-1:0]                lanes_calc;
    logic [TILE_SIZE-1:0]         lane_ok;
    logic [TDW-1:0]               x_masked;
    logic [DW-1:0]                wl;
    logic [DW-1:0]                xl;
    logic [PW-1:0]                prod;
    logic signed [ACC_WIDTH-1:0]  tile_sum;
    logic signed [ACC_WIDTH:0]    v_ext;
    logic signed [ACC_WIDTH:0]    rnd;
    logic signed [ACC_WIDTH:0]    v_rnd;
    logic signed [ACC_WIDTH:0]    v_sh;
    logic [DW-1:0]                y_next;

    // Readies and busy come straight from the state register, never from valids.
    assign x_ready = (state == S_LOAD_X);
    assign b_ready = (state == S_BIAS);
    assign w_ready = (state == S_MAC);
    assign busy    = (state != S_IDLE);

    // Config validation and per-job tile geometry derived from cols_cfg.
    always_comb begin
        cfg_ok     = (rows_cfg != '0) && (rows_cfg <= RW'(MAX_ROWS)) &&
                     (cols_cfg != '0) && (cols_cfg <= CW'(MAX_COLS));
        cols_round = {1'b0, cols_cfg} + (CW+1)'(TILE_SIZE - 1);
        tiles_calc = TW'(cols_round / (CW+1)'(TILE_SIZE));
        lanes_calc = LW'((cols_cfg - CW'(1)) % CW'(TILE_SIZE)) + LW'(1);
    end

    // Lanes past cols_cfg in the final tile contribute nothing.
    always_comb begin
        lane_ok  = '0;
        x_masked = '0;
        for (int i = 0; i < TILE_SIZE; i++) begin
            lane_ok[i] = (tile_left != '0) || (LW'(i) < last_lanes);
            x_masked[i*DW +: DW] = lane_ok[i] ? x_data[i*DW +: DW] : '0;
        end
    end

    // Tile dot product: sign-extended 16-bit products summed at accumulator width.
    always_comb begin
        tile_sum = '0;
        wl       = '0;
        xl       = '0;
        prod     = '0;
        for (int i = 0; i < TILE_SIZE; i++) begin
            wl       = lane_ok[i] ? w_data[i*DW +: DW] : '0;
            xl       = x_buf[tile_idx][i*DW +: DW];
            prod     = {{DW{wl[DW-1]}}, wl} * {{DW{xl[DW-1]}}, xl};
            tile_sum = tile_sum + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
        end
    end

    // Requantisation one bit wider than acc so the rounding add cannot overflow.
    always_comb begin
        v_ext = (relu_q && acc[ACC_WIDTH-1]) ? '0 : {acc[ACC_WIDTH-1], acc};
        rnd   = '0;
        if (shift_q != 5'd0) begin
            rnd = (ACC_WIDTH+1)'(1) << (shift_q - 5'd1);
        end
        v_rnd = v_ext + rnd;
        v_sh  = v_rnd >>> shift_q;
        if (v_sh > SAT_MAX) begin
            y_next = DW'(SAT_MAX);
        end else if (v_sh < SAT_MIN) begin
            y_next = DW'(SAT_MIN);
        end else begin
            y_next = v_sh[DW-1:0];
        end
    end

    // x buffer capture during LOAD_X, masked lanes stored as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int t = 0; t < MAX_TILES; t++) begin
                x_buf[t] <= '0;
            end
        end else if (state == S_LOAD_X && x_valid) begin
            x_buf[tile_idx] <= x_masked;
        end
    end

    // Job sequencing FSM with registered result and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            rows_left  <= '0;
            tiles_q    <= '0;
            tile_left  <= '0;
            tile_idx   <= '0;
            last_lanes <= '0;
            relu_q     <= 1'b0;
            shift_q    <= '0;
            acc        <= '0;
            y_valid    <= 1'b0;
            y_data     <= '0;
            y_last     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            rows_left  <= rows_cfg - RW'(1);
                            tiles_q    <= tiles_calc;
                            tile_left  <= tiles_calc - TW'(1);
                            tile_idx   <= '0;
                            last_lanes <= lanes_calc;
                            relu_q     <= relu_en;
                            shift_q    <= shift;
                            state      <= S_LOAD_X;
                        end else begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end
                    end
                end
                S_LOAD_X: begin
                    if (x_valid) begin
                        if (tile_left == '0) begin
                            state <= S_BIAS;
                        end else begin
                            tile_left <= tile_left - TW'(1);
                            tile_idx  <= tile_idx + IW'(1);
                        end
                    end
                end
                S_BIAS: begin
                    if (b_valid) begin
                        acc       <= {{(ACC_WIDTH-DW){b_data[DW-1]}}, b_data};
                        tile_left <= tiles_q - TW'(1);
                        tile_idx  <= '0;
                        state     <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (w_valid) begin
                        acc <= acc + tile_sum;
                        if (tile_left == '0) begin
                            state <= S_REQUANT;
                        end else begin
                            tile_left <= tile_left - TW'(1);
                            tile_idx  <= tile_idx + IW'(1);
                        end
                    end
                end
                S_REQUANT: begin
                    y_data  <= y_next;
                    y_valid <= 1'b1;
                    y_last  <= (rows_left == '0);
                    state   <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        y_last  <= 1'b0;
                        if (rows_left == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            rows_left <= rows_left - RW'(1);
                            state     <= S_BIAS;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
